// File: rtl/dsp_vadd_arbiter.sv
// Two-requester round-robin front end feeding a two-stage, four-lane 8-bit
// wrap-around vector adder with a single stall enable driven by resp_ready.
module dsp_vadd_arbiter #(
    parameter int W     = 8,
    parameter int LANES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [W*LANES-1:0] req0_a,
    input  logic [W*LANES-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [W*LANES-1:0] req1_a,
    input  logic [W*LANES-1:0] req1_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [W*LANES-1:0] resp_y,
    output logic               busy
);

    // Each lane wraps modulo 2^W; carries never cross lane boundaries.
    function automatic logic [W*LANES-1:0] lane_add(input logic [W*LANES-1:0] a,
                                                    input logic [W*LANES-1:0] b);
        logic [W*LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*W +: W] = a[i*W +: W] + b[i*W +: W];
        end
        return r;
    endfunction

    logic               en;
    logic               gnt_vld;
    logic               gnt_id;
    logic               prio_q, prio_d;

    logic               vld_p1_q, vld_p1_d;
    logic               id_p1_q, id_p1_d;
    logic [W*LANES-1:0] a_p1_q, a_p1_d;
    logic [W*LANES-1:0] b_p1_q, b_p1_d;

    logic               vld_p2_q, vld_p2_d;
    logic               id_p2_q, id_p2_d;
    logic [W*LANES-1:0] y_p2_q, y_p2_d;

    always_comb begin
        en         = !(vld_p2_q && !resp_ready);
        gnt_vld    = req0_valid || req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = !reset && en && gnt_vld && !gnt_id;
        req1_ready = !reset && en && gnt_vld && gnt_id;

        prio_d   = prio_q;
        vld_p1_d = vld_p1_q;
        id_p1_d  = id_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        vld_p2_d = vld_p2_q;
        id_p2_d  = id_p2_q;
        y_p2_d   = y_p2_q;

        if (en) begin
            // Stage 0 -> 1: arbitrated operands enter the input register
            vld_p1_d = gnt_vld;
            id_p1_d  = gnt_id;
            a_p1_d   = gnt_id ? req1_a : req0_a;
            b_p1_d   = gnt_id ? req1_b : req0_b;
            if (gnt_vld) begin
                prio_d = !gnt_id;
            end
            // Stage 1 -> 2: bubbles leave the last result fields untouched
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                id_p2_d = id_p1_q;
                y_p2_d  = lane_add(a_p1_q, b_p1_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q   <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            id_p2_q  <= 1'b0;
            y_p2_q   <= '0;
        end else begin
            prio_q   <= prio_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            id_p2_q  <= id_p2_d;
            y_p2_q   <= y_p2_d;
        end
    end

    always_ff @(posedge clock) begin
        id_p1_q <= id_p1_d;
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
    end

    assign resp_valid = vld_p2_q;
    assign resp_id    = id_p2_q;
    assign resp_y     = y_p2_q;
    assign busy       = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_dsp_vadd_arbiter.sv
// Bench for dsp_vadd_arbiter: vector table, directed multi-cycle sequences and
// random traffic checked against a queue-based reference model.
module tb_dsp_vadd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b1;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, resp_valid, resp_id, busy;
    logic [31:0] resp_y;

    dsp_vadd_arbiter #(.W(8), .LANES(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            s = (((a >> (8 * i)) & 32'hFF) + ((b >> (8 * i)) & 32'hFF)) % 256;
            y = y | (s << (8 * i));
        end
        return y;
    endfunction

    // Reference model: in-flight results in acceptance order, each tagged with
    // the number of enabled edges it has seen; one or more means it is presented.
    typedef struct {
        logic        id;
        logic [31:0] y;
        int          age;
    } ent_t;
    ent_t        mq[$];
    bit          mon_on = 1'b0;
    logic        m_prio = 1'b0;
    logic        m_rv, m_en, m_g, m_gid;
    logic [31:0] m_a, m_b;
    logic        obs_t0, obs_t1, obs_both;
    int          last_gnt = -1;

    always @(negedge clock) begin
        if (mon_on) begin
            m_rv  = (mq.size() > 0) && (mq[0].age >= 1);
            m_en  = !(m_rv && !resp_ready);
            m_g   = !reset && m_en && (req0_valid || req1_valid);
            m_gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
            m_a   = m_gid ? req1_a : req0_a;
            m_b   = m_gid ? req1_b : req0_b;
            chk("m_req0_ready", req0_ready, m_g && !m_gid);
            chk("m_req1_ready", req1_ready, m_g && m_gid);
            chk("m_resp_valid", resp_valid, m_rv);
            chk("m_busy", busy, mq.size() > 0);
            if (m_rv) begin
                chk("m_resp_id", resp_id, mq[0].id);
                chk("m_resp_y", resp_y, mq[0].y);
            end
            obs_t0   = req0_valid && req0_ready;
            obs_t1   = req1_valid && req1_ready;
            obs_both = req0_valid && req1_valid;
        end
    end

    always @(posedge clock) begin
        if (mon_on) begin
            if (reset) begin
                mq.delete();
                m_prio   = 1'b0;
                last_gnt = -1;
            end else begin
                if (obs_both && (obs_t0 || obs_t1) && last_gnt >= 0) begin
                    chk("fair_alternate", obs_t1 != last_gnt[0], 1);
                end
                if (obs_t0 || obs_t1) last_gnt = obs_t1 ? 1 : 0;
                if (m_en) begin
                    if (m_rv && resp_ready) void'(mq.pop_front());
                    foreach (mq[i]) mq[i].age++;
                    if (m_g) begin
                        mq.push_back('{id: m_gid, y: ref_sum(m_a, m_b), age: 0});
                        m_prio = !m_gid;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (n) next_cycle();
    endtask

    typedef struct {
        bit          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cap_y;
        logic        cap_id;
        logic        ids[$];
        logic [31:0] ys[$];
        int          lat, first_c, last_c, cnt;

        tbl[0] = '{0, 32'h01FF807F, 32'h0101807F, 32'h020000FE};
        tbl[1] = '{1, 32'hFFFFFFFF, 32'h01010101, 32'h00000000};
        tbl[2] = '{0, 32'h00000000, 32'h00000000, 32'h00000000};
        tbl[3] = '{1, 32'h12345678, 32'h11111111, 32'h23456789};
        tbl[4] = '{0, 32'h80808080, 32'h80808080, 32'h00000000};
        tbl[5] = '{1, 32'h7F7F7F7F, 32'h01020304, 32'h80818283};
        tbl[6] = '{0, 32'hA5C30F01, 32'h5B3DF1FF, 32'h00000000};

        mon_on = 1'b1;
        reset  = 1'b1;
        repeat (2) next_cycle();
        @(negedge clock);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_y", resp_y, 0);
        chk("rst_resp_id", resp_id, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Vector table: single transfers; result visible after the second edge
        // counting the accepting one.
        foreach (tbl[k]) begin
            resp_ready = 1'b1;
            if (tbl[k].port) begin
                req1_valid = 1'b1; req1_a = tbl[k].a; req1_b = tbl[k].b;
            end else begin
                req0_valid = 1'b1; req0_a = tbl[k].a; req0_b = tbl[k].b;
            end
            @(negedge clock);
            chk("tbl_ready", tbl[k].port ? req1_ready : req0_ready, 1);
            next_cycle();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            lat = 0;
            @(negedge clock);
            while (!resp_valid && lat < 5) begin
                next_cycle();
                lat++;
                @(negedge clock);
            end
            chk("tbl_latency", lat, 1);
            chk("tbl_resp_y", resp_y, tbl[k].y);
            chk("tbl_resp_id", resp_id, tbl[k].port);
            idle(2);
        end

        // Contention straight out of reset
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        ids.delete();
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i < 4);
            req1_valid = (i < 4);
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            @(negedge clock);
            if (i < 4) begin
                chk("cont_req0_ready", req0_ready, (i % 2) == 0);
                chk("cont_req1_ready", req1_ready, (i % 2) == 1);
            end
            if (resp_valid) ids.push_back(resp_id);
            next_cycle();
        end
        chk("cont_resp_count", ids.size(), 4);
        for (int i = 0; i < ids.size(); i++) chk("cont_resp_id", ids[i], i % 2);
        idle(2);

        // Backpressure with two results in flight
        req0_valid = 1'b1; req0_a = 32'h10203040; req0_b = 32'h01020304;
        @(negedge clock);
        chk("bp_acc0", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h01FF01FF;
        @(negedge clock);
        chk("bp_acc1", req1_ready, 1);
        next_cycle();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        @(negedge clock);
        cap_y  = resp_y;
        cap_id = resp_id;
        chk("bp_first_y", cap_y, 32'h11223344);
        chk("bp_first_id", cap_id, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            chk("bp_valid", resp_valid, 1);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_hold_y", resp_y, cap_y);
            chk("bp_hold_id", resp_id, cap_id);
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        ids.delete();
        ys.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                ids.push_back(resp_id);
                ys.push_back(resp_y);
            end
            next_cycle();
        end
        chk("bp_count", ids.size(), 2);
        if (ids.size() == 2) begin
            chk("bp_order_id0", ids[0], 0);
            chk("bp_order_y0", ys[0], 32'h11223344);
            chk("bp_order_id1", ids[1], 1);
            chk("bp_order_y1", ys[1], 32'h00FF00FF);
        end

        // Requester 1 streaming alone
        cnt = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < 16; i++) begin
            req1_valid = (i < 10);
            req1_a = $urandom; req1_b = $urandom;
            @(negedge clock);
            if (i < 10) chk("stream_ready", req1_ready, 1);
            if (resp_valid) begin
                chk("stream_id", resp_id, 1);
                cnt++;
                if (first_c < 0) first_c = i;
                last_c = i;
            end
            next_cycle();
        end
        chk("stream_count", cnt, 10);
        chk("stream_span", last_c - first_c, 9);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clock);
        chk("stream_prio_r0", req0_ready, 1);
        chk("stream_prio_r1", req1_ready, 0);
        next_cycle();
        idle(3);

        // Reset with two entries in flight
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
        next_cycle();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rstf_busy_before", busy, 1);
        chk("rstf_req0_ready", req0_ready, 0);
        chk("rstf_req1_ready", req1_ready, 0);
        next_cycle();
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rstf_resp_valid", resp_valid, 0);
            chk("rstf_busy", busy, 0);
            next_cycle();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clock);
        chk("rstf_grant_r0", req0_ready, 1);
        chk("rstf_grant_r1", req1_ready, 0);
        next_cycle();
        idle(3);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            resp_ready = ($urandom_range(0, 99) < 70);
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            next_cycle();
        end
        idle(4);
        chk("rand_drained", mq.size(), 0);
        chk("rand_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
